gng_out_buf: RTL and testbench
==============================

# gng_out_buf

Output buffer downstream of the polynomial interpolation stage of the Gaussian noise generator. The interpolator emits s<16,11> samples on a bare valid strobe and has no backpressure. This block absorbs those samples in a FIFO and presents them to the consumer over a valid/ready handshake. It reports fill level, almost-full and a sticky overflow flag.

## Interface
Parameters:
- DEPTH, 16, number of sample slots; power of two, ≥ 4
- AFULL_TH, 12, level at or above which almost_full asserts; 1 ≤ AFULL_TH ≤ DEPTH

Ports:
- clk  in  1  system clock
- rstn  in  1  system reset; asynchronous, active low
- clear  in  1  synchronous flush
- valid_in  in  1  input sample valid; no backpressure toward the source
- data_in  in  16  input sample, signed s<16,11>
- valid_out  out  1  output sample valid
- ready_out  in  1  consumer ready
- data_out  out  16  output sample, signed s<16,11>
- level  out  $clog2(DEPTH)+1  samples held, including the output register
- almost_full  out  1  level ≥ AFULL_TH
- overflow  out  1  sticky; a sample was dropped
- drop_cnt  out  16  dropped-sample count; present only with GNG_OUT_BUF_STATS_EN

## Operation
- Event definitions:
  - pop = valid_out & ready_out
  - push = valid_in & !clear & (level < DEPTH | pop)
  - drop = valid_in & !clear & level == DEPTH & !pop
- Storage is a circular buffer of DEPTH entries followed by a show-ahead output register. Read and write pointers wrap modulo DEPTH.
- Ordering is strict FIFO. Data is never altered; the 16-bit pattern is passed through unchanged.
- When the output register is empty or popped, it reloads from the buffer head. If the buffer is empty, it loads directly from data_in on a push (bypass).
- valid_out stays high with data_out stable while ready_out is low.
- When valid_out is low, data_out holds its last value.
- Simultaneous push and pop at level == DEPTH: both happen and level is unchanged. No drop occurs.
- drop: the sample is discarded, overflow sets, and the stored contents are untouched.
- clear has priority over everything:
  - On the next edge, pointers, level, valid_out, overflow (and drop_cnt) go to 0.
  - A valid_in on the same cycle as clear is discarded and is not counted as a drop.
- rstn low at any time, including mid-burst, asynchronously forces:
  - valid_out = 0, data_out = 0, level = 0, almost_full = 0, overflow = 0, drop_cnt = 0.
- almost_full and level are registered and updated on the same edge as the push or pop.

## Timing
- Latency from an empty buffer: a push at edge k gives valid_out = 1 and data_out = the sample after edge k.
- Throughput is one sample per cycle in and out, sustained with ready_out held high.
- level increments after the push edge and decrements after the pop edge.
- overflow rises after the first drop edge and stays high until clear or rstn.
- valid_in may be asserted every cycle; the source cannot be stalled.

## Configuration
- GNG_OUT_BUF_STATS_EN:
  - Defined: drop_cnt exists and increments on each drop. It saturates at 16'hFFFF and is cleared by clear or rstn.
  - Undefined: the drop_cnt port and its logic are absent; overflow is still present.

## Structure
- Shared package gng_pkg holds:
  - GNG_SAMPLE_W = 16
  - typedef gng_sample_t, signed [GNG_SAMPLE_W-1:0]
  - GNG_FRAC_W = 11
- One sub-module, gng_out_buf_mem: DEPTH × 16 simple dual-port storage.
  - Synchronous write.
  - Combinational read at the read pointer.
- Pointer, level and flag logic plus the output register live in gng_out_buf.

## Test plan
- Single sample:
  - Stimulus: after reset, one valid_in with data_in = 16'sh0800 (+1.0), ready_out = 1.
  - Required: valid_out = 1 with data_out = 16'h0800 for exactly one cycle, one edge after the push; level returns to 0.
- Backpressure fill:
  - Stimulus: ready_out = 0, push 16 samples 0..15.
  - Required: level = 16; almost_full high from the 12th push; overflow = 0; data_out = 0 held.
- Overflow:
  - Stimulus: full buffer, ready_out = 0, two more pushes.
  - Required: overflow = 1, drop_cnt = 2 (with the macro); then drain with ready_out = 1 yields exactly 0..15 in order.
- Full push+pop:
  - Stimulus: full buffer, valid_in and ready_out both high for 20 cycles.
  - Required: level stays 16, overflow stays 0, output sequence is contiguous with no gaps.
- Clear and async reset:
  - Stimulus: clear with valid_in high at level 5.
  - Required: level = 0, valid_out = 0, drop_cnt unchanged at 0.
  - Stimulus: rstn pulsed low mid-clock during a burst.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
- Random soak:
  - Stimulus: random valid_in (p = 0.7) and ready_out (p = 0.5) for 10k cycles.
  - Required: the scoreboard matches accepted samples in order, and level equals pushes − pops − flushed at every cycle.

Source files
------------

// File: rtl/gng_pkg.sv
// Shared definitions for the Gaussian noise generator datapath.
//   GNG_SAMPLE_W : sample width in bits
//   GNG_FRAC_W   : fractional bits of the s<16,11> sample format
//   gng_sample_t : signed sample type
package gng_pkg;

   localparam int GNG_SAMPLE_W = 16;
   localparam int GNG_FRAC_W   = 11;

   typedef logic signed [GNG_SAMPLE_W-1:0] gng_sample_t;

endpackage

// File: rtl/gng_out_buf_mem.sv
// Sample storage for gng_out_buf: DEPTH x GNG_SAMPLE_W simple dual-port array.
// The write is synchronous. The read is combinational, so the output register
// can load the buffer head on the same edge that it is popped.
//   clk   : system clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data at raddr (combinational)
module gng_out_buf_mem
   import gng_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [AW-1:0]           waddr,
   input  logic [GNG_SAMPLE_W-1:0] wdata,
   input  logic [AW-1:0]           raddr,
   output logic [GNG_SAMPLE_W-1:0] rdata
);

   gng_sample_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/gng_out_buf.sv
// Output buffer for the Gaussian noise generator. It absorbs interpolator
// samples, which arrive on a bare valid strobe with no backpressure, and
// presents them to the consumer over a valid/ready handshake. Storage is a
// circular buffer followed by a show-ahead output register.
//
// Optional feature macro: GNG_OUT_BUF_STATS_EN adds the drop_cnt port.
//
//   clk         : system clock
//   rstn        : asynchronous active-low reset
//   clear       : synchronous flush (highest priority)
//   valid_in    : input sample strobe
//   data_in     : input sample, s<16,11>
//   valid_out   : output sample valid
//   ready_out   : consumer ready
//   data_out    : output sample, s<16,11>; holds its last value while idle
//   level       : samples held, including the output register
//   almost_full : level >= AFULL_TH
//   overflow    : sticky, set when a sample was dropped
//   drop_cnt    : saturating dropped-sample count (GNG_OUT_BUF_STATS_EN only)
module gng_out_buf
   import gng_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int AFULL_TH = 12
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    clear,
   input  logic                    valid_in,
   input  logic [GNG_SAMPLE_W-1:0] data_in,
   output logic                    valid_out,
   input  logic                    ready_out,
   output logic [GNG_SAMPLE_W-1:0] data_out,
   output logic [$clog2(DEPTH):0]  level,
   output logic                    almost_full,
   output logic                    overflow
`ifdef GNG_OUT_BUF_STATS_EN
   ,
   output logic [15:0]             drop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_AF   = LW'(AFULL_TH);

   logic [AW-1:0]           wr_ptr;
   logic [AW-1:0]           rd_ptr;
   logic [LW-1:0]           buf_cnt;
   logic [LW-1:0]           level_nxt;
   logic [GNG_SAMPLE_W-1:0] mem_rdata;

   logic pop;
   logic push;
   logic drop;
   logic at_full;
   logic out_free;
   logic buf_empty;
   logic buf_rd;
   logic buf_wr;
   logic bypass;

   always_comb begin
      pop       = valid_out & ready_out;
      at_full   = (level == LVL_FULL);
      push      = valid_in & ~clear & (~at_full | pop);
      drop      = valid_in & ~clear & at_full & ~pop;
      // The output register takes a new sample whenever it is empty or popped.
      out_free  = ~valid_out | pop;
      buf_empty = (buf_cnt == '0);
      buf_rd    = out_free & ~buf_empty;
      // With nothing queued behind it, a free output register takes the
      // incoming sample directly so an empty buffer has one-edge latency.
      bypass    = out_free & buf_empty & push;
      buf_wr    = push & ~bypass;
      level_nxt = level + LW'(push) - LW'(pop);
   end

   gng_out_buf_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk   (clk),
      .we    (buf_wr),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         buf_cnt     <= '0;
         level       <= '0;
         almost_full <= 1'b0;
         valid_out   <= 1'b0;
         data_out    <= '0;
         overflow    <= 1'b0;
      end else if (clear) begin
         // data_out is left alone: it simply holds while valid_out is low.
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         buf_cnt     <= '0;
         level       <= '0;
         almost_full <= 1'b0;
         valid_out   <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         if (buf_wr) wr_ptr <= wr_ptr + 1'b1;
         if (buf_rd) rd_ptr <= rd_ptr + 1'b1;
         buf_cnt     <= buf_cnt + LW'(buf_wr) - LW'(buf_rd);
         level       <= level_nxt;
         almost_full <= (level_nxt >= LVL_AF);
         if (out_free) begin
            if (buf_rd) begin
               valid_out <= 1'b1;
               data_out  <= mem_rdata;
            end else if (push) begin
               valid_out <= 1'b1;
               data_out  <= data_in;
            end else begin
               valid_out <= 1'b0;
            end
         end
         if (drop) overflow <= 1'b1;
      end
   end

`ifdef GNG_OUT_BUF_STATS_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         drop_cnt <= '0;
      end else if (clear) begin
         drop_cnt <= '0;
      end else if (drop && drop_cnt != 16'hFFFF) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_gng_out_buf.sv
module tb_gng_out_buf;

   localparam int DEPTH    = 16;
   localparam int AFULL_TH = 12;
   localparam int LW       = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rstn;
   logic          clear;
   logic          valid_in;
   logic [15:0]   data_in;
   logic          valid_out;
   logic          ready_out;
   logic [15:0]   data_out;
   logic [LW-1:0] level;
   logic          almost_full;
   logic          overflow;
`ifdef GNG_OUT_BUF_STATS_EN
   logic [15:0]   drop_cnt;
`endif

   gng_out_buf #(
      .DEPTH    (DEPTH),
      .AFULL_TH (AFULL_TH)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .clear       (clear),
      .valid_in    (valid_in),
      .data_in     (data_in),
      .valid_out   (valid_out),
      .ready_out   (ready_out),
      .data_out    (data_out),
      .level       (level),
      .almost_full (almost_full),
      .overflow    (overflow)
`ifdef GNG_OUT_BUF_STATS_EN
      ,
      .drop_cnt    (drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the queue holds every sample the block currently owns,
   // head first (head = the sample being presented on data_out).
   logic [15:0] q[$];
   logic [15:0] last_head;
   logic        m_ovf;
   int          m_drops;

   int n_vec;
   int n_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      last_head = '0;
      m_ovf     = 1'b0;
      m_drops   = 0;
   endtask

   // One clock edge of the model, using the inputs that were held across it.
   task automatic model_edge(input logic vin, input logic [15:0] din,
                             input logic rdy, input logic clr);
      logic pop_e;
      logic was_full;
      pop_e    = (q.size() > 0) && rdy;
      was_full = (q.size() == DEPTH);
      if (clr) begin
         q.delete();
         m_ovf   = 1'b0;
         m_drops = 0;
      end else begin
         if (pop_e) void'(q.pop_front());
         if (vin) begin
            if (!was_full || pop_e) begin
               q.push_back(din);
            end else begin
               m_ovf = 1'b1;
               if (m_drops < 65535) m_drops++;
            end
         end
      end
      if (q.size() > 0) last_head = q[0];
   endtask

   task automatic compare_all();
      check("valid_out", 32'(valid_out), 32'(q.size() > 0));
      check("data_out", 32'(data_out), 32'((q.size() > 0) ? q[0] : last_head));
      check("level", 32'(level), 32'(q.size()));
      check("almost_full", 32'(almost_full), 32'(q.size() >= AFULL_TH));
      check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef GNG_OUT_BUF_STATS_EN
      check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif
   endtask

   task automatic step(input logic vin, input logic [15:0] din,
                       input logic rdy, input logic clr);
      @(negedge clk);
      valid_in  = vin;
      data_in   = din;
      ready_out = rdy;
      clear     = clr;
      @(posedge clk);
      model_edge(vin, din, rdy, clr);
      #1;
      compare_all();
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      rstn      = 1'b0;
      clear     = 1'b0;
      valid_in  = 1'b0;
      data_in   = '0;
      ready_out = 1'b0;
      model_reset();

      repeat (2) @(posedge clk);
      #1;
      compare_all();
      @(negedge clk);
      rstn = 1'b1;

      // Single sample, +1.0, straight through the bypass path.
      step(1'b1, 16'h0800, 1'b1, 1'b0);
      check("single_data", 32'(data_out), 32'h0800);
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      check("single_gone", 32'(valid_out), 32'd0);

      // Fill under backpressure, then two drops.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
      check("fill_level", 32'(level), 32'(DEPTH));
      step(1'b1, 16'h7AAA, 1'b0, 1'b0);
      step(1'b1, 16'h7BBB, 1'b0, 1'b0);
      check("ovf_set", 32'(overflow), 32'd1);
`ifdef GNG_OUT_BUF_STATS_EN
      check("ovf_drops", 32'(drop_cnt), 32'd2);
`endif

      // Drain: the handshake must yield exactly 0..15.
      for (int i = 0; i < DEPTH; i++) begin
         check("drain_order", 32'(data_out), 32'(i));
         step(1'b0, 16'h0000, 1'b1, 1'b0);
      end
      check("drain_empty", 32'(level), 32'd0);

      // Clear flushes the sticky flag; refill to full, then push+pop at full.
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) step(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         check("fullpp_seq", 32'(data_out), 32'(16'h0100 + i));
         step(1'b1, 16'(16'h0100 + DEPTH + i), 1'b1, 1'b0);
         check("fullpp_level", 32'(level), 32'(DEPTH));
      end
      check("fullpp_ovf", 32'(overflow), 32'd0);

      // Clear with valid_in high at level 5.
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
      step(1'b1, 16'h1234, 1'b0, 1'b1);
      check("clear_level", 32'(level), 32'd0);
      check("clear_vout", 32'(valid_out), 32'd0);

      // Asynchronous reset in the middle of a burst.
      for (int i = 0; i < 7; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0);
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = 16'h5555;
      #2;
      rstn = 1'b0;
      #1;
      check("arst_vout", 32'(valid_out), 32'd0);
      check("arst_data", 32'(data_out), 32'd0);
      check("arst_level", 32'(level), 32'd0);
      check("arst_af", 32'(almost_full), 32'd0);
      check("arst_ovf", 32'(overflow), 32'd0);
`ifdef GNG_OUT_BUF_STATS_EN
      check("arst_drops", 32'(drop_cnt), 32'd0);
`endif
      model_reset();
      @(negedge clk);
      valid_in  = 1'b0;
      ready_out = 1'b0;
      @(negedge clk);
      rstn = 1'b1;

      // Random soak with occasional flushes.
      for (int i = 0; i < 10000; i++) begin
         step(($urandom_range(0, 9) < 7), 16'($urandom), ($urandom_range(0, 1) == 1),
              ($urandom_range(0, 249) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
